serial_addsub: RTL and testbench



---
 rtl/serial_addsub_pkg.sv | 19 +
 rtl/serial_addsub_if.sv | 44 ++++
 rtl/serial_addsub_fa.sv | 13 +
 rtl/serial_addsub.sv | 116 +++++++++++
 tb/tb_serial_addsub.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
// Holds the FSM state encoding, the operation codes and the counter sizing helper.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // A one-bit word still needs a one-bit counter, so the width never drops to zero.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand and result handshake bundle for serial_addsub.
// The master side is the operand source plus result sink; the slave side is the engine.
interface serial_addsub_if #(
    parameter int WORD_WIDTH = 4
);

    // Valid/ready rules: a beat transfers on a rising clk edge where valid&ready are
    // both 1; valid, once raised, holds with its payload stable until that edge;
    // ready may rise or fall freely and never depends on the valid of the same channel.
    logic [WORD_WIDTH-1:0] a;
    logic [WORD_WIDTH-1:0] b;
    logic                  op;
    logic                  in_vld;
    logic                  in_rd;
    logic [WORD_WIDTH-1:0] out_res;
    logic                  out_cb;
    logic                  out_vld;
    logic                  out_rd;

    modport master (
        output a,
        output b,
        output op,
        output in_vld,
        input  in_rd,
        input  out_res,
        input  out_cb,
        input  out_vld,
        output out_rd
    );

    modport slave (
        input  a,
        input  b,
        input  op,
        input  in_vld,
        output in_rd,
        output out_res,
        output out_cb,
        output out_vld,
        input  out_rd
    );

endinterface

// File: rtl/serial_addsub_fa.sv
// Single full-adder cell; the serial engine reuses it once per bit position.
module serial_addsub_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic co,
    output logic s
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract engine: one full-adder cell walks the operands LSB first,
// one bit per clock, and presents the word result with carry/borrow on a handshake.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WORD_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus,
    output state_t         dbg_state
);

    localparam int CW = cnt_width(WORD_WIDTH);

    state_t                state;
    state_t                state_nxt;

    logic [WORD_WIDTH-1:0] a_sh;
    logic [WORD_WIDTH-1:0] b_sh;
    logic [WORD_WIDTH-1:0] res;
    logic                  carry;
    logic                  op_q;
    logic [CW-1:0]         cnt;

    logic                  fa_s;
    logic                  fa_co;
    logic                  accept;
    logic                  last_bit;

    assign accept   = (state == IDLE) && bus.in_vld;
    assign last_bit = (cnt == CW'(WORD_WIDTH - 1));

    serial_addsub_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .co (fa_co),
        .s  (fa_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)     state_nxt = RUN;
            RUN:  if (last_bit)   state_nxt = DONE;
            DONE: if (bus.out_rd) state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: b is inverted at load and the +1 enters as carry-in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            op_q  <= OP_ADD;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh  <= bus.a;
                        b_sh  <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        carry <= bus.op;
                        op_q  <= bus.op;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    // New sum bit enters at the MSB so the LSB lands at bit 0 after the last shift.
                    res   <= (res >> 1) | (WORD_WIDTH'(fa_s) << (WORD_WIDTH - 1));
                    carry <= fa_co;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    cnt   <= cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic; in_rd is forced low while reset is asserted.
    always_comb begin
        bus.in_rd   = 1'b0;
        bus.out_vld = 1'b0;
        bus.out_res = '0;
        bus.out_cb  = 1'b0;
        case (state)
            IDLE: bus.in_rd = rst_n;
            DONE: begin
                bus.out_vld = 1'b1;
                bus.out_res = res;
                bus.out_cb  = (op_q == OP_SUB) ? ~carry : carry;
            end
            default: begin
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed testbench for serial_addsub at WORD_WIDTH=4 with hand-computed results.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     n_cmp;
    int     n_err;

    logic [4:0] exp_q[$];

    serial_addsub_if #(.WORD_WIDTH(4)) bus ();

    serial_addsub #(.WORD_WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks; all are entered and left at a falling edge.
    task automatic send_op(input logic [3:0] a, input logic [3:0] b, input logic op);
        int waited;
        bus.a      = a;
        bus.b      = b;
        bus.op     = op;
        bus.in_vld = 1'b1;
        waited     = 0;
        while (bus.in_rd !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_vld = 1'b0;
        bus.a      = ~a;
        bus.b      = ~b;
        bus.op     = ~op;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_vld !== 1'b1 && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (bus.out_vld !== 1'b1) lat = -1;
    endtask

    task automatic consume();
        bus.out_rd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_rd = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.in_rd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_in_rd: got %b expected 0", bus.in_rd);
        end
        n_cmp++;
        if (bus.out_vld !== 1'b0 || bus.out_res !== 4'd0 || bus.out_cb !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got vld=%b res=%0d cb=%b expected 0/0/0",
                     bus.out_vld, bus.out_res, bus.out_cb);
        end
        n_cmp++;
        if (dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_rd !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_in_rd: got %b expected 1", bus.in_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_sub();
        int lat;
        send_op(4'd5, 4'd3, OP_SUB);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL sub_5_3_latency: got %0d expected 4", lat);
        end
        n_cmp++;
        if (bus.out_res !== 4'd2 || bus.out_cb !== 1'b0) begin
            n_err++;
            $display("FAIL sub_5_3: got res=%0d cb=%b expected res=2 cb=0", bus.out_res, bus.out_cb);
        end
        consume();
        send_op(4'd3, 4'd5, OP_SUB);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4 || bus.out_res !== 4'd14 || bus.out_cb !== 1'b1) begin
            n_err++;
            $display("FAIL sub_3_5: got lat=%0d res=%0d cb=%b expected lat=4 res=14 cb=1",
                     lat, bus.out_res, bus.out_cb);
        end
        consume();
        send_op(4'd0, 4'd0, OP_SUB);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4 || bus.out_res !== 4'd0 || bus.out_cb !== 1'b0) begin
            n_err++;
            $display("FAIL sub_0_0: got lat=%0d res=%0d cb=%b expected lat=4 res=0 cb=0",
                     lat, bus.out_res, bus.out_cb);
        end
        consume();
    endtask

    task automatic test_add();
        int lat;
        send_op(4'd15, 4'd1, OP_ADD);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4 || bus.out_res !== 4'd0 || bus.out_cb !== 1'b1) begin
            n_err++;
            $display("FAIL add_15_1: got lat=%0d res=%0d cb=%b expected lat=4 res=0 cb=1",
                     lat, bus.out_res, bus.out_cb);
        end
        consume();
        send_op(4'd6, 4'd7, OP_ADD);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4 || bus.out_res !== 4'd13 || bus.out_cb !== 1'b0) begin
            n_err++;
            $display("FAIL add_6_7: got lat=%0d res=%0d cb=%b expected lat=4 res=13 cb=0",
                     lat, bus.out_res, bus.out_cb);
        end
        consume();
    endtask

    task automatic test_idle_out_rd();
        int bad;
        bad = 0;
        bus.out_rd = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_vld !== 1'b0 || dbg_state !== IDLE || bus.in_rd !== 1'b1) bad++;
        end
        bus.out_rd = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_out_rd: got %0d disturbed cycles expected 0", bad);
        end
    endtask

    task automatic test_stall();
        int lat;
        int bad;
        send_op(4'd12, 4'd7, OP_SUB);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL stall_latency: got %0d expected 4", lat);
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_vld !== 1'b1 || bus.out_res !== 4'd5 || bus.out_cb !== 1'b0 ||
                bus.in_rd !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold: got vld=%b res=%0d cb=%b in_rd=%b expected 1/5/0/0",
                         bus.out_vld, bus.out_res, bus.out_cb, bus.in_rd);
            end
        end
        n_cmp++;
        if (bad != 0) n_err++;
        consume();
        n_cmp++;
        if (dbg_state !== IDLE || bus.out_vld !== 1'b0 || bus.in_rd !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got state=%0d vld=%b in_rd=%b expected IDLE/0/1",
                     dbg_state, bus.out_vld, bus.in_rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [0:2];
        logic [3:0] vb [0:2];
        logic       vo [0:2];
        logic [4:0] ve [0:2];
        logic [4:0] exp;
        logic       will_accept;
        int sent;
        int got;
        int cyc;
        int last_acc;
        va = '{4'd3, 4'd10, 4'd7};
        vb = '{4'd8, 4'd2, 4'd9};
        vo = '{OP_ADD, OP_SUB, OP_SUB};
        ve = '{5'b0_1011, 5'b0_1000, 5'b1_1110};
        sent = 0;
        got = 0;
        cyc = 0;
        last_acc = -1;
        bus.out_rd = 1'b1;
        bus.a      = va[0];
        bus.b      = vb[0];
        bus.op     = vo[0];
        bus.in_vld = 1'b1;
        while (got < 3 && cyc < 80) begin
            will_accept = 1'b0;
            if (bus.in_vld === 1'b1 && bus.in_rd === 1'b1) begin
                will_accept = 1'b1;
                exp_q.push_back(ve[sent]);
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc != 6) begin
                        n_err++;
                        $display("FAIL b2b_spacing: got %0d cycles expected 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
            end
            if (bus.out_vld === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_extra: got res=%0d cb=%b expected no result",
                             bus.out_res, bus.out_cb);
                end else begin
                    exp = exp_q.pop_front();
                    if ({bus.out_cb, bus.out_res} !== exp) begin
                        n_err++;
                        $display("FAIL b2b_result_%0d: got cb=%b res=%0d expected cb=%b res=%0d",
                                 got, bus.out_cb, bus.out_res, exp[4], exp[3:0]);
                    end
                end
                got++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (will_accept) begin
                sent++;
                if (sent < 3) begin
                    bus.a  = va[sent];
                    bus.b  = vb[sent];
                    bus.op = vo[sent];
                end else begin
                    bus.in_vld = 1'b0;
                end
            end
        end
        bus.in_vld = 1'b0;
        bus.out_rd = 1'b0;
        n_cmp++;
        if (got != 3 || sent != 3 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count: got sent=%0d results=%0d pending=%0d expected 3/3/0",
                     sent, got, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int bad;
        send_op(4'd1, 4'd1, OP_ADD);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_vld !== 1'b0 || bus.in_rd !== 1'b0 || dbg_state !== IDLE ||
            bus.out_res !== 4'd0) begin
            n_err++;
            $display("FAIL midrun_reset: got vld=%b in_rd=%b state=%0d res=%0d expected 0/0/IDLE/0",
                     bus.out_vld, bus.in_rd, dbg_state, bus.out_res);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.in_rd !== 1'b1 || bus.out_vld !== 1'b0) begin
            n_err++;
            $display("FAIL midrun_release: got in_rd=%b vld=%b expected 1/0", bus.in_rd, bus.out_vld);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.out_vld !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midrun_discard: got %0d cycles with stale out_vld expected 0", bad);
        end
        send_op(4'd9, 4'd4, OP_SUB);
        wait_done(lat);
        n_cmp++;
        if (lat !== 4 || bus.out_res !== 4'd5 || bus.out_cb !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_9_4: got lat=%0d res=%0d cb=%b expected lat=4 res=5 cb=0",
                     lat, bus.out_res, bus.out_cb);
        end
        consume();
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.op     = OP_ADD;
        bus.in_vld = 1'b0;
        bus.out_rd = 1'b0;
        @(negedge clk);
        test_reset();
        test_sub();
        test_add();
        test_idle_out_rd();
        test_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
